// File: rtl/prng_sample_fifo.sv
// Consumer stage for the xoshiro128++ generator. It draws words, optionally reduces them to
// [0, bound) by mask-and-reject, and buffers the results in a small prefetch FIFO.
module prng_sample_fifo #(
    parameter int DEPTH   = 4,
    parameter int STARTUP = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   gen_next,
    input  logic [31:0]            gen_rnd,
    input  logic                   gen_write,
    input  logic                   flush,
    input  logic [31:0]            bound,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            reject_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = (STARTUP > 1) ? $clog2(STARTUP) : 1;
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT,
        S_REQ,
        S_CAP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] start_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem [DEPTH];

    logic        flush_i;
    logic [31:0] smear;
    logic [31:0] mask;
    logic [31:0] masked;
    logic [31:0] push_data;
    logic        accept;
    logic        push;
    logic        pop;
    logic        reject;

    // A seed write invalidates everything buffered, exactly like an explicit flush.
    assign flush_i = flush | gen_write;

    // Smallest all-ones mask covering bound-1; bound==0 selects the full 32-bit range.
    always_comb begin
        // NOTE: blocking assignments are correct here; each line refines the previous value
        // within the same evaluation, and no state is held between evaluations.
        smear = bound - 32'd1;
        smear = smear | (smear >> 1);
        smear = smear | (smear >> 2);
        smear = smear | (smear >> 4);
        smear = smear | (smear >> 8);
        smear = smear | (smear >> 16);
        mask  = (bound == 32'd0) ? 32'hFFFF_FFFF : smear;
    end

    assign masked    = gen_rnd & mask;
    assign accept    = (bound == 32'd0) || (masked < bound);
    assign push_data = (bound == 32'd0) ? gen_rnd : masked;
    assign push      = (state == S_CAP) && accept && !flush_i;
    assign reject    = (state == S_CAP) && !accept && !flush_i;

    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready && !flush_i;
    assign out_data  = out_valid ? mem[rd_ptr] : 32'h0;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        state_nxt = state;
        gen_next  = 1'b0;
        case (state)
            S_WAIT: begin
                if (start_cnt == START_LAST) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Space is reserved at request time; pops can only add room before the push.
                gen_next = (level < FULL_LEVEL) && !flush_i;
                if (gen_next) begin
                    state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                state_nxt = S_REQ;
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_WAIT;
            start_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            reject_cnt <= '0;
        end else begin
            state <= state_nxt;

            if ((state == S_WAIT) && (start_cnt != START_LAST)) begin
                start_cnt <= start_cnt + SW'(1);
            end

            if (reject && (reject_cnt != 16'hFFFF)) begin
                reject_cnt <= reject_cnt + 16'd1;
            end

            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; level gates out_data, so stale entries are
    // never observable and the array can map onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_prng_sample_fifo.sv
// Directed bench for prng_sample_fifo: a stub generator feeds hand-picked words and queues
// the hand-computed result of each; an independent monitor checks every pop against it.
`timescale 1ns/1ps
module tb_prng_sample_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gen_next;
    logic [31:0] gen_rnd = 32'h0;
    logic        gen_write = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] bound = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  level;
    logic [15:0] reject_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cnt = 0;
    int pops = 0;
    int last_pop = -1;
    bit spacing_on = 1'b0;
    int gen_idx = 0;

    logic [31:0] vec_word[$];
    bit          vec_acc[$];
    logic [31:0] vec_exp[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    prng_sample_fifo #(.DEPTH(4), .STARTUP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .gen_next   (gen_next),
        .gen_rnd    (gen_rnd),
        .gen_write  (gen_write),
        .flush      (flush),
        .bound      (bound),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .reject_cnt (reject_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic add_vec(input logic [31:0] w, input bit acc, input logic [31:0] e);
        vec_word.push_back(w);
        vec_acc.push_back(acc);
        vec_exp.push_back(e);
    endtask

    // Expected results below are worked out by hand for the bound of each phase.
    task automatic load_vectors(input int phase);
        vec_word.delete();
        vec_acc.delete();
        vec_exp.delete();
        case (phase)
            0: begin // bound=0: words pass through untouched
                add_vec(32'hFEF316C3, 1, 32'hFEF316C3);
                add_vec(32'h12345678, 1, 32'h12345678);
                add_vec(32'hDEADBEEF, 1, 32'hDEADBEEF);
                add_vec(32'h0BADF00D, 1, 32'h0BADF00D);
                add_vec(32'h80000001, 1, 32'h80000001);
                add_vec(32'hFFFFFFFF, 1, 32'hFFFFFFFF);
                add_vec(32'h00000000, 1, 32'h00000000);
                add_vec(32'hA5A5A5A5, 1, 32'hA5A5A5A5);
            end
            1: begin // bound=100, mask 0x7F: 4 accepts, 4 rejects
                add_vec(32'hFEF316C3, 1, 32'h00000043);
                add_vec(32'h12345678, 0, 32'h0);
                add_vec(32'hDEADBEEF, 0, 32'h0);
                add_vec(32'h0BADF00D, 1, 32'h0000000D);
                add_vec(32'h80000063, 1, 32'h00000063);
                add_vec(32'h80000064, 0, 32'h0);
                add_vec(32'h0000007F, 0, 32'h0);
                add_vec(32'hFFFFFF80, 1, 32'h00000000);
            end
            2: begin // bound=5, mask 7: 5 accepts, 3 rejects
                add_vec(32'h00000010, 1, 32'h0);
                add_vec(32'h00000021, 1, 32'h1);
                add_vec(32'h00000037, 0, 32'h0);
                add_vec(32'h00000044, 1, 32'h4);
                add_vec(32'h00000055, 0, 32'h0);
                add_vec(32'hFFFFFFF3, 1, 32'h3);
                add_vec(32'h00000006, 0, 32'h0);
                add_vec(32'h0000000A, 1, 32'h2);
            end
            default: begin // bound=1, mask 0: everything becomes 0
                add_vec(32'hFFFFFFFF, 1, 32'h0);
                add_vec(32'h12345678, 1, 32'h0);
                add_vec(32'h80000001, 1, 32'h0);
            end
        endcase
    endtask

    // Stub generator: answers each request one cycle later; a table past its end yields 0.
    always @(posedge clk) begin
        if (gen_next === 1'b1) req_cnt++;
        if (rst || flush || gen_write) begin
            gen_idx = 0;
            exp_q.delete();
        end else if (gen_next === 1'b1) begin
            if (gen_idx < vec_word.size()) begin
                gen_rnd <= vec_word[gen_idx];
                if (vec_acc[gen_idx]) exp_q.push_back(vec_exp[gen_idx]);
            end else begin
                gen_rnd <= 32'h0;
                exp_q.push_back(32'h0);
            end
            gen_idx++;
        end
    end

    // Monitor: samples mid-cycle, where a pop at the next edge is already decided.
    always @(negedge clk) begin
        cyc++;
        if (!spacing_on) last_pop = -1;
        if (!rst) begin
            if (!out_valid) check("out_data_idle", out_data, 32'h0);
            if (out_valid && out_ready && !flush && !gen_write) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got %h, expected no word", out_data);
                end else begin
                    check("pop_data", out_data, exp_q.pop_front());
                end
                if (spacing_on && last_pop >= 0) check("pop_spacing", 32'(cyc - last_pop), 32'd2);
                last_pop = cyc;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] b, input int phase);
        drive_edge();
        rst       = 1'b1;
        out_ready = 1'b0;
        bound     = b;
        load_vectors(phase);
        repeat (3) drive_edge();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int found;
        int req_before;
        int pops_before;

        load_vectors(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gen_next", {31'h0, gen_next}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_level", {29'h0, level}, 32'h0);
        check("rst_reject_cnt", {16'h0, reject_cnt}, 32'h0);

        // Startup delay, then the first word lands with out_ready low.
        drive_edge();
        rst = 1'b0;
        found = -1;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (gen_next === 1'b1) begin
                found = n;
                break;
            end
        end
        check("first_gen_next_cycle", 32'(found), 32'd5);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (level != 3'd0) begin
                found = 1;
                break;
            end
        end
        check("first_level_seen", 32'(found), 32'd1);
        check("first_out_data", out_data, 32'hFEF316C3);
        check("first_level", {29'h0, level}, 32'd1);

        // Fill to DEPTH, requests stop; one pop allows exactly one more request.
        repeat (20) @(negedge clk);
        check("full_level", {29'h0, level}, 32'd4);
        check("full_req_cnt", 32'(req_cnt), 32'd4);
        check("full_gen_next", {31'h0, gen_next}, 32'h0);
        drive_edge(); out_ready = 1'b1;
        drive_edge(); out_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("refill_req_cnt", 32'(req_cnt), 32'd5);
        check("refill_level", {29'h0, level}, 32'd4);

        // Pop, then pop again in the capture cycle so push and pop coincide.
        drive_edge(); out_ready = 1'b1;
        drive_edge(); out_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gen_next === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("req_after_pop", 32'(found), 32'd1);
        drive_edge(); out_ready = 1'b1;
        drive_edge(); out_ready = 1'b0;
        @(negedge clk);
        check("push_pop_level", {29'h0, level}, 32'd3);

        // Seed write while a capture is pending, with three words buffered.
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (gen_next === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("req_before_seed", 32'(found), 32'd1);
        drive_edge(); gen_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("seed_level", {29'h0, level}, 32'd0);
        check("seed_out_valid", {31'h0, out_valid}, 32'h0);
        check("seed_out_data", out_data, 32'h0);
        req_before = req_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("seed_gen_next", {31'h0, gen_next}, 32'h0);
        end
        check("seed_req_cnt", 32'(req_cnt), 32'(req_before));
        drive_edge(); gen_write = 1'b0;
        repeat (20) @(negedge clk);
        check("after_seed_level", {29'h0, level}, 32'd4);

        // Explicit flush of a full buffer.
        drive_edge(); flush = 1'b1;
        drive_edge(); flush = 1'b0;
        @(negedge clk);
        check("flush_level", {29'h0, level}, 32'd0);
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);

        // Continuous consumer: one word every two cycles, empty pops ignored.
        do_reset(32'd0, 0);
        out_ready  = 1'b1;
        spacing_on = 1'b1;
        pops_before = pops;
        repeat (3) @(negedge clk);
        check("empty_pop_level", {29'h0, level}, 32'd0);
        repeat (37) @(negedge clk);
        spacing_on = 1'b0;
        check("stream_pop_count", {31'h0, (pops - pops_before) >= 10}, 32'd1);

        // bound=100: first output 0x43, four rejects including m==100 and m==127.
        do_reset(32'd100, 1);
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("bound100_rejects", {16'h0, reject_cnt}, 32'd4);

        // bound=5 then bound=1 via flush; reject_cnt survives the flush.
        do_reset(32'd5, 2);
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("bound5_rejects", {16'h0, reject_cnt}, 32'd3);
        drive_edge(); out_ready = 1'b0;
        repeat (20) @(negedge clk);
        drive_edge();
        load_vectors(3);
        bound = 32'd1;
        flush = 1'b1;
        drive_edge(); flush = 1'b0; out_ready = 1'b1;
        pops_before = pops;
        repeat (30) @(negedge clk);
        check("bound1_rejects", {16'h0, reject_cnt}, 32'd3);
        check("bound1_pops", {31'h0, (pops - pops_before) >= 5}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
